// File: rtl/inst_sequencer_if.sv
// Handshake and instruction bus between the run controller and inst_sequencer.
// The master side starts runs and supplies configuration. The slave side is the
// sequencer, which returns the instruction word and run status.
interface inst_sequencer_if;
  logic        start;
  logic [3:0]  cfg_nkij;
  logic [7:0]  cfg_len;
  logic [10:0] cfg_wbase;
  logic [10:0] cfg_abase;
  logic [10:0] cfg_pbase;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;

  modport master (
    output start, cfg_nkij, cfg_len, cfg_wbase, cfg_abase, cfg_pbase, ofifo_valid,
    input  inst, busy, done
  );

  modport slave (
    input  start, cfg_nkij, cfg_len, cfg_wbase, cfg_abase, cfg_pbase, ofifo_valid,
    output inst, busy, done
  );
endinterface

// File: rtl/inst_sequencer.sv
// inst_sequencer: steps a PE-array core through weight load, flush, activation
// execute, drain and psum write-back for each kernel position of a run.
// Optional macro SEQ_ACC_EN adds a final ACC phase that drives the acc bit and
// reads back psum rows from pbase.
module inst_sequencer #(
  parameter int unsigned row   = 8,
  parameter int unsigned col   = 8,
  parameter int unsigned flush = 16
) (
  input  logic              clk,
  input  logic              reset,
  inst_sequencer_if.slave   bus
);

  if (row < 1 || col < 1 || flush < 1) begin : g_param_check
    $error("inst_sequencer: row, col and flush must all be at least 1");
  end

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    IDLE, W_L0, W_LD, FLUSH, A_L0, EXEC, DRAIN, O_RD, NEXT, DONE
`ifdef SEQ_ACC_EN
    , ACC
`endif
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [3:0]  k, k_n;
  logic [15:0] phase_len;
  logic        last_beat;
  logic [3:0]  k_inc;

  logic [3:0]  nkij_q, nkij_c;
  logic [7:0]  len_q, len_c;
  logic [10:0] wbase_q, wbase_c, abase_q, abase_c, pbase_q, pbase_c;

  logic [33:0] inst_q, inst_n;
  logic        acc_b, pcen, pwen, xcen, xwen, ord_b, l0r, l0w, exe, ld;
  logic [10:0] paddr, xaddr, beat11;

  // Configuration follows the inputs while idle, so the start edge sees the new
  // values and the first beat can use them before the latched copy exists.
  always_comb begin
    if (state == IDLE) begin
      nkij_c  = (bus.cfg_nkij == '0) ? 4'd1 : bus.cfg_nkij;
      len_c   = (bus.cfg_len  == '0) ? 8'd1 : bus.cfg_len;
      wbase_c = bus.cfg_wbase;
      abase_c = bus.cfg_abase;
      pbase_c = bus.cfg_pbase;
    end else begin
      nkij_c  = nkij_q;
      len_c   = len_q;
      wbase_c = wbase_q;
      abase_c = abase_q;
      pbase_c = pbase_q;
    end
  end

  // State, counters, latched configuration and the registered instruction word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      k       <= '0;
      inst_q  <= IDLE_WORD;
      nkij_q  <= '0;
      len_q   <= '0;
      wbase_q <= '0;
      abase_q <= '0;
      pbase_q <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      k       <= k_n;
      inst_q  <= inst_n;
      nkij_q  <= nkij_c;
      len_q   <= len_c;
      wbase_q <= wbase_c;
      abase_q <= abase_c;
      pbase_q <= pbase_c;
    end
  end

  // Next state and beat counter; every phase entry restarts the beat count at 0.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    k_n     = k;
    k_inc   = k + 4'd1;
    case (state)
      W_L0, W_LD:             phase_len = 16'(col);
      FLUSH:                  phase_len = 16'(flush);
      A_L0, EXEC, O_RD:       phase_len = {8'd0, len_c};
`ifdef SEQ_ACC_EN
      ACC:                    phase_len = {8'd0, len_c};
`endif
      default:                phase_len = 16'd1;
    endcase
    last_beat = (cnt == phase_len - 16'd1);

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.start) begin
          state_n = W_L0;
          k_n     = '0;
        end
      end
      W_L0:  if (last_beat) begin state_n = W_LD;  cnt_n = '0; end
      W_LD:  if (last_beat) begin state_n = FLUSH; cnt_n = '0; end
      FLUSH: if (last_beat) begin state_n = A_L0;  cnt_n = '0; end
      A_L0:  if (last_beat) begin state_n = EXEC;  cnt_n = '0; end
      EXEC:  if (last_beat) begin state_n = DRAIN; cnt_n = '0; end
      DRAIN: begin
        cnt_n = '0;
        if (bus.ofifo_valid) state_n = O_RD;
      end
      O_RD:  if (last_beat) begin state_n = NEXT;  cnt_n = '0; end
      NEXT: begin
        cnt_n = '0;
        k_n   = k_inc;
        if (k_inc < nkij_c) state_n = W_L0;
`ifdef SEQ_ACC_EN
        else                state_n = ACC;
`else
        else                state_n = DONE;
`endif
      end
`ifdef SEQ_ACC_EN
      ACC:   if (last_beat) begin state_n = DONE;  cnt_n = '0; end
`endif
      DONE: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Instruction word for the coming cycle, decoded from next state and beat so
  // that the entry edge already carries the first beat of a phase.
  always_comb begin
    acc_b  = 1'b0;
    pcen   = 1'b1;
    pwen   = 1'b1;
    xcen   = 1'b1;
    xwen   = 1'b1;
    ord_b  = 1'b0;
    l0r    = 1'b0;
    l0w    = 1'b0;
    exe    = 1'b0;
    ld     = 1'b0;
    paddr  = '0;
    xaddr  = '0;
    beat11 = cnt_n[10:0];
    case (state_n)
      W_L0: begin
        xcen  = 1'b0;
        l0w   = 1'b1;
        xaddr = wbase_c + ({7'd0, k_n} * 11'(col)) + beat11;
      end
      W_LD: begin
        l0r = 1'b1;
        ld  = 1'b1;
      end
      A_L0: begin
        xcen  = 1'b0;
        l0w   = 1'b1;
        xaddr = abase_c + beat11;
      end
      EXEC: begin
        l0r = 1'b1;
        exe = 1'b1;
      end
      O_RD: begin
        ord_b = 1'b1;
        pcen  = 1'b0;
        pwen  = 1'b0;
        paddr = pbase_c + ({7'd0, k_n} * {3'd0, len_c}) + beat11;
      end
`ifdef SEQ_ACC_EN
      ACC: begin
        acc_b = 1'b1;
        pcen  = 1'b0;
        paddr = pbase_c + beat11;
      end
`endif
      default: ;
    endcase
    inst_n = {acc_b, pcen, pwen, paddr, xcen, xwen, xaddr,
              ord_b, 1'b0, 1'b0, l0r, l0w, exe, ld};
  end

  assign bus.inst = inst_q;
  assign bus.busy = (state != IDLE) && (state != DONE);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed testbench for inst_sequencer with hand-computed expectations.
// Works in both builds; SEQ_ACC_EN adds the ACC beats to the expected timing.
module tb_inst_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  inst_sequencer_if bus ();

  inst_sequencer #(.row(8), .col(8), .flush(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
`ifdef SEQ_ACC_EN
  localparam int ACC = 1;
`else
  localparam int ACC = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  logic [10:0] xq[$];
  logic [10:0] pq[$];
  logic [10:0] aq[$];
  int n_l0w, n_ld, n_ex, n_ord, n_acc, done_cyc, done_cnt;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] q_at(input logic [10:0] q[$], input int i);
    if (i < q.size()) return {53'd0, q[i]};
    return 64'hDEAD;
  endfunction

  // Starts one run, logs every beat until done, then checks that a start in the
  // DONE cycle is ignored and that done pulses only once.
  task automatic run(input logic [3:0] nk, input logic [7:0] ln,
                     input logic [10:0] wb, input logic [10:0] ab, input logic [10:0] pb,
                     input int limit);
    int extra_done;
    xq.delete(); pq.delete(); aq.delete();
    n_l0w = 0; n_ld = 0; n_ex = 0; n_ord = 0; n_acc = 0;
    done_cyc = -1; done_cnt = 0;
    bus.cfg_nkij = nk; bus.cfg_len = ln;
    bus.cfg_wbase = wb; bus.cfg_abase = ab; bus.cfg_pbase = pb;
    bus.start = 1'b1;
    cyc = 0;
    step();
    bus.start = 1'b0;
    check_eq("busy_first_cycle", {63'd0, bus.busy}, 64'd1);
    // latched configuration must be immune to later input changes
    bus.cfg_nkij = 4'hF; bus.cfg_len = 8'hFF;
    bus.cfg_wbase = 11'h555; bus.cfg_abase = 11'h2AA; bus.cfg_pbase = 11'h333;
    while (cyc < limit) begin
      if (!bus.inst[19]) xq.push_back(bus.inst[17:7]);
      if (!bus.inst[32] && !bus.inst[31]) pq.push_back(bus.inst[30:20]);
      if (!bus.inst[32] &&  bus.inst[31]) aq.push_back(bus.inst[30:20]);
      if (bus.inst[2]) n_l0w++;
      if (bus.inst[0]) n_ld++;
      if (bus.inst[1]) n_ex++;
      if (bus.inst[6]) n_ord++;
      if (bus.inst[33]) n_acc++;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        break;
      end
      bus.start = (cyc == 5);
      step();
    end
    bus.start = 1'b0;
    if (done_cyc > 0) begin
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check_eq("start_at_done_busy", {63'd0, bus.busy}, 64'd0);
      check_eq("start_at_done_inst", {30'd0, bus.inst}, {30'd0, IDLE_W});
      extra_done = 0;
      for (int i = 0; i < 3; i++) begin
        step();
        if (bus.done) extra_done++;
      end
      check_eq("single_done_pulse", done_cnt + extra_done, 1);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_nkij = '0; bus.cfg_len = '0;
    bus.cfg_wbase = '0; bus.cfg_abase = '0; bus.cfg_pbase = '0;
    bus.ofifo_valid = 1'b1;
    reset = 1'b1;
    cyc = 0;

    // idle after reset
    step(); step();
    reset = 1'b0;
    check_eq("reset_inst", {30'd0, bus.inst}, {30'd0, IDLE_W});
    check_eq("reset_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("reset_done", {63'd0, bus.done}, 64'd0);
    step();

    // single kernel position
    run(4'd1, 8'd4, 11'h010, 11'h100, 11'h200, 300);
    check_eq("p1_done_cycle", done_cyc, 47 + 4 * ACC);
    check_eq("p1_xq_size", xq.size(), 12);
    for (int i = 0; i < 8; i++) check_eq("p1_wt_addr", q_at(xq, i), 64'h10 + i);
    for (int i = 0; i < 4; i++) check_eq("p1_act_addr", q_at(xq, 8 + i), 64'h100 + i);
    check_eq("p1_pq_size", pq.size(), 4);
    for (int i = 0; i < 4; i++) check_eq("p1_psum_addr", q_at(pq, i), 64'h200 + i);
    check_eq("p1_l0_wr_beats", n_l0w, 12);
    check_eq("p1_load_beats", n_ld, 8);
    check_eq("p1_exec_beats", n_ex, 4);
    check_eq("p1_ofifo_rd_beats", n_ord, 4);
    check_eq("p1_acc_beats", n_acc, 4 * ACC);

    // three positions, psum address wraps at 2048
    run(4'd3, 8'd8, 11'h020, 11'h040, 11'h7F8, 600);
    check_eq("p3_done_cycle", done_cyc, 175 + 8 * ACC);
    check_eq("p3_xq_size", xq.size(), 48);
    for (int kk = 0; kk < 3; kk++) check_eq("p3_wt_base", q_at(xq, kk * 16), 64'h20 + 8 * kk);
    check_eq("p3_pq_size", pq.size(), 24);
    for (int i = 0; i < 24; i++) check_eq("p3_psum_wrap", q_at(pq, i), (64'h7F8 + i) & 64'h7FF);
    check_eq("p3_aq_size", aq.size(), 8 * ACC);
`ifdef SEQ_ACC_EN
    for (int i = 0; i < 8; i++) check_eq("p3_acc_addr", q_at(aq, i), (64'h7F8 + i) & 64'h7FF);
`endif

    // zero-valued nkij/len act as 1; weight address wraps
    run(4'd0, 8'd0, 11'h7FE, 11'h7FF, 11'h7FF, 200);
    check_eq("z_done_cycle", done_cyc, 38 + ACC);
    check_eq("z_xq_size", xq.size(), 9);
    check_eq("z_wt_wrap", q_at(xq, 2), 64'h0);
    check_eq("z_act_addr", q_at(xq, 8), 64'h7FF);
    check_eq("z_pq_size", pq.size(), 1);
    check_eq("z_psum_addr", q_at(pq, 0), 64'h7FF);

    // two positions with ACC expectations (ACC beats only in that build)
    run(4'd2, 8'd4, 11'h000, 11'h080, 11'h3F0, 300);
    check_eq("a_done_cycle", done_cyc, 93 + 4 * ACC);
    check_eq("a_acc_beats", n_acc, 4 * ACC);
    check_eq("a_aq_size", aq.size(), 4 * ACC);
`ifdef SEQ_ACC_EN
    for (int i = 0; i < 4; i++) check_eq("a_acc_addr", q_at(aq, i), 64'h3F0 + i);
`endif

    // drain stall: DRAIN entered at cycle 41 for nkij=1, len=4
    begin
      int bad;
      int guard;
      bus.cfg_nkij = 4'd1; bus.cfg_len = 8'd4;
      bus.cfg_wbase = 11'h010; bus.cfg_abase = 11'h100; bus.cfg_pbase = 11'h200;
      bus.ofifo_valid = 1'b0;
      bus.start = 1'b1;
      cyc = 0;
      step();
      bus.start = 1'b0;
      while (cyc < 40) step();
      check_eq("drain_pre_exec", {30'd0, bus.inst}, {30'd0, IDLE_W | 34'hA});
      step();
      bad = 0;
      for (int j = 0; j < 50; j++) begin
        if (bus.inst !== IDLE_W || bus.busy !== 1'b1) bad++;
        if (j < 49) step();
      end
      check_eq("drain_stall_idle_busy", bad, 0);
      bus.ofifo_valid = 1'b1;
      step();
      check_eq("drain_first_ord", {30'd0, bus.inst}, {30'd0, 34'h0_200C_0040});
      guard = 0;
      while (!bus.done && guard < 100) begin
        step();
        guard++;
      end
      check_eq("drain_done_seen", {63'd0, bus.done}, 64'd1);
      step();
    end

    // reset during EXEC beat 2 (cycle 39), then a clean replay
    bus.cfg_nkij = 4'd2; bus.cfg_len = 8'd4;
    bus.cfg_wbase = 11'h030; bus.cfg_abase = 11'h060; bus.cfg_pbase = 11'h100;
    bus.start = 1'b1;
    cyc = 0;
    step();
    bus.start = 1'b0;
    while (cyc < 39) step();
    check_eq("mid_exec_beat2", {30'd0, bus.inst}, {30'd0, IDLE_W | 34'hA});
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_reset_inst", {30'd0, bus.inst}, {30'd0, IDLE_W});
    check_eq("mid_reset_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("mid_reset_done", {63'd0, bus.done}, 64'd0);
    step();
    run(4'd2, 8'd4, 11'h030, 11'h060, 11'h100, 300);
    check_eq("replay_first_wt", q_at(xq, 0), 64'h30);
    check_eq("replay_done_cycle", done_cyc, 93 + 4 * ACC);
    check_eq("replay_pq_size", pq.size(), 8);
    check_eq("replay_psum0", q_at(pq, 0), 64'h100);
    check_eq("replay_psum4", q_at(pq, 4), 64'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameter: row, default 8, PE array rows.
REQ-002 Parameter: col, default 8, PE array columns and the number of weight vectors per kernel position.
REQ-003 Parameter: flush, default 16, idle cycles between the weight-load and activation phases.
REQ-004 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  one-cycle pulse that begins a run; sampled only in IDLE.
REQ-007 Port: cfg_nkij  input  4  number of kernel positions per run; 0 is treated as 1.
REQ-008 Port: cfg_len  input  8  activation vectors per kernel position; 0 is treated as 1.
REQ-009 Port: cfg_wbase, cfg_abase, cfg_pbase  input  11 each  weight, activation and psum base addresses.
REQ-010 Port: ofifo_valid  input  1  output FIFO holds a complete result row.
REQ-011 Port: inst  output  34  registered instruction word driven to the core.
REQ-012 Port: busy  output  1  high from the cycle after start is accepted until done.
REQ-013 Port: done  output  1  one-cycle pulse at run completion.

Function
REQ-014 inst field map:
- [33] acc
- [32] pmem CEN
- [31] pmem WEN
- [30:20] pmem address
- [19] xmem CEN
- [18] xmem WEN
- [17:7] xmem address
- [6] ofifo_rd
- [5] ififo_wr
- [4] ififo_rd
- [3] l0_rd
- [2] l0_wr
- [1] execute
- [0] load
REQ-015 IDLE word = 34'h1_800C_0000: both CEN/WEN high, addresses 0, other bits 0; inst SHALL equal this in every cycle not listed below.
REQ-016 States: IDLE, W_L0, W_LD, FLUSH, A_L0, EXEC, DRAIN, O_RD, NEXT, DONE; plus ACC when SEQ_ACC_EN is defined.
REQ-017 IDLE to W_L0 on start.
- cfg_* SHALL be latched on that edge.
- Kernel index k is cleared.
REQ-018 W_L0 lasts col cycles, beat i = 0..col-1: xmem CEN=0, WEN=1, address = wbase + k*col + i; l0_wr=1.
REQ-019 W_LD lasts col cycles: l0_rd=1, load=1.
REQ-020 FLUSH lasts flush cycles with the idle word.
REQ-021 A_L0 lasts len cycles, beat i: xmem CEN=0, WEN=1, address = abase + i; l0_wr=1.
REQ-022 EXEC lasts len cycles: l0_rd=1, execute=1.
REQ-023 DRAIN holds the idle word until ofifo_valid=1, then enters O_RD in the next cycle; DRAIN has no timeout.
REQ-024 O_RD lasts len cycles, beat i: ofifo_rd=1, pmem CEN=0, WEN=0, address = pbase + k*len + i.
REQ-025 NEXT lasts one cycle: k increments; if k < nkij go to W_L0, else go to DONE (or ACC, see REQ-032).
REQ-026 DONE lasts one cycle: done=1, busy=0, then IDLE.
REQ-027 All address arithmetic is modulo 2048 (11-bit wrap, no saturation).
REQ-028 start is ignored while busy; start in the same cycle as DONE is ignored.
REQ-029 inst changes are registered: the state entry edge and the first beat word are the same cycle.

Reset
REQ-030 Reset takes precedence over all inputs and works mid-run:
- next cycle: state=IDLE, inst = idle word, busy=0, done=0, k=0, beat counter 0;
- no partial beat completes.

Configuration
REQ-031 Macro SEQ_ACC_EN selects the optional ACC phase.
REQ-032 With SEQ_ACC_EN defined: after the last NEXT, ACC lasts len cycles, beat i: acc=1, pmem CEN=0, WEN=1, address = pbase + i, then DONE.
REQ-033 Without SEQ_ACC_EN: the ACC state and acc logic are absent, inst[33] is constant 0, and the last NEXT goes to DONE.

Verification
REQ-034 Idle after reset: reset high for 2 cycles -> inst=34'h1_800C_0000, busy=0, done=0.
REQ-035 Single position: nkij=1, len=4, wbase=0x10, abase=0x100, pbase=0x200, ofifo_valid tied 1 -> results:
- xmem addresses 0x10..0x17, then 0x100..0x103;
- pmem writes 0x200..0x203;
- one done pulse, 8+8+16+4+4+1+4+1+1 cycles after start (47 without SEQ_ACC_EN).
REQ-036 Multi-position wrap: nkij=3, len=8, pbase=0x7F8 -> pmem writes 0x7F8..0x7FF, 0x000..0x007, 0x008..0x00F; weight bases wbase+0, +8, +16.
REQ-037 Drain stall: ofifo_valid held 0 for 50 cycles in DRAIN -> inst stays idle, busy=1; ofifo_rd asserts the cycle after ofifo_valid rises.
REQ-038 Mid-run reset: reset asserted in EXEC beat 2 -> next cycle idle word, busy=0; a new start replays from W_L0 with k=0.
REQ-039 SEQ_ACC_EN build: nkij=2, len=4 -> 4 ACC beats with inst[33]=1 and pmem addresses pbase..pbase+3, before done.
